// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding, byte width and baud divisor
// used by the arbiter and the uart_rx/uart_tx blocks.
package uart_pkg;

    localparam int DATA_W   = 8;
    localparam int BAUD_DIV = 5208;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_GUARD = 2'd2,
        ST_WAIT  = 2'd3
    } arb_state_e;

    function automatic int wrap_inc(input int idx, input int modulus);
        return (idx + 1 >= modulus) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: lowest set request at or above ptr,
// wrapping, found by a priority encode over the request vector doubled.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [PTR_W-1:0]   winner_idx,
    output logic               found
);

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [2*NUM_REQ-1:0] masked_s;
    logic                 sel_s;

    // Mask the lower copy below ptr, then take the first set bit upward.
    always_comb begin
        dbl_s      = {req, req};
        masked_s   = '0;
        found      = 1'b0;
        sel_s      = 1'b0;
        winner_idx = '0;
        for (int i = 0; i < 2 * NUM_REQ; i++) begin
            masked_s[i] = dbl_s[i] && (i >= int'(ptr));
            sel_s       = masked_s[i] && !found;
            found       = found || masked_s[i];
            winner_idx  = sel_s ? PTR_W'(i % NUM_REQ) : winner_idx;
        end
        winner = found ? (NUM_REQ'(1) << winner_idx) : '0;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, burst-locking arbiter sharing one uart_tx between NUM_REQ
// byte-stream requesters; drives tx_start/tx_data and watches tx_busy.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = 4,
    parameter int DATA_W    = 8
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      arb_busy
);

    import uart_pkg::*;

    localparam int         PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] BURST_CAP = 8'(MAX_BURST);

    arb_state_e           state_r;
    logic [NUM_REQ-1:0]   grant_r;
    logic [PTR_W-1:0]     gidx_r;
    logic [PTR_W-1:0]     ptr_r;
    logic [7:0]           burst_r;
    logic                 last_f_r;
    logic                 tx_start_r;
    logic [DATA_W-1:0]    tx_data_r;
    logic                 arb_busy_r;

    logic [NUM_REQ-1:0]   pick_oh_s;
    logic [PTR_W-1:0]     pick_idx_s;
    logic                 pick_any_s;
    logic                 sel_valid_s;
    logic                 sel_last_s;
    logic [DATA_W-1:0]    sel_data_s;
    logic                 more_s;
    logic [PTR_W-1:0]     ptr_next_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req        (req_valid),
        .ptr        (ptr_r),
        .winner     (pick_oh_s),
        .winner_idx (pick_idx_s),
        .found      (pick_any_s)
    );

    assign sel_valid_s = req_valid[gidx_r];
    assign sel_last_s  = req_last[gidx_r];
    assign sel_data_s  = req_data[gidx_r*DATA_W +: DATA_W];
    assign more_s      = !last_f_r && (burst_r < BURST_CAP) && sel_valid_s;
    assign ptr_next_s  = PTR_W'(wrap_inc(int'(gidx_r), NUM_REQ));

    assign req_ready = (state_r == ST_SEND) ? (req_valid & grant_r) : '0;
    assign tx_start  = tx_start_r;
    assign tx_data   = tx_data_r;
    assign grant     = grant_r;
    assign arb_busy  = arb_busy_r;

    // Arbitration FSM with burst counter, byte register and start pulse.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r    <= ST_IDLE;
            grant_r    <= '0;
            gidx_r     <= '0;
            ptr_r      <= '0;
            burst_r    <= 8'd0;
            last_f_r   <= 1'b0;
            tx_start_r <= 1'b0;
            tx_data_r  <= '0;
            arb_busy_r <= 1'b0;
        end else begin
            tx_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // A frame still running from before a reset must finish first.
                    if (!tx_busy && pick_any_s) begin
                        grant_r    <= pick_oh_s;
                        gidx_r     <= pick_idx_s;
                        burst_r    <= 8'd0;
                        state_r    <= ST_SEND;
                        arb_busy_r <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (sel_valid_s) begin
                        tx_data_r  <= sel_data_s;
                        tx_start_r <= 1'b1;
                        last_f_r   <= sel_last_s;
                        burst_r    <= (burst_r < BURST_CAP) ? burst_r + 8'd1 : burst_r;
                        state_r    <= ST_GUARD;
                    end else begin
                        grant_r    <= '0;
                        ptr_r      <= ptr_next_s;
                        state_r    <= ST_IDLE;
                        arb_busy_r <= 1'b0;
                    end
                end
                ST_GUARD: begin
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!tx_busy) begin
                        if (more_s) begin
                            state_r <= ST_SEND;
                        end else begin
                            grant_r    <= '0;
                            ptr_r      <= ptr_next_s;
                            state_r    <= ST_IDLE;
                            arb_busy_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    grant_r    <= '0;
                    state_r    <= ST_IDLE;
                    arb_busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: behavioural uart_tx (20-cycle busy),
// queue-fed requesters, and hand-computed transmit orders.
module tb_uart_tx_arbiter;

    logic        sys_clk    = 1'b0;
    logic        sys_rst    = 1'b1;
    logic [1:0]  req_valid  = 2'b00;
    logic [1:0]  req_last   = 2'b00;
    logic [15:0] req_data   = 16'h0000;
    logic [1:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant;
    logic        arb_busy;

    int          total      = 0;
    int          bad        = 0;
    int          busy_cnt   = 0;
    logic        force_busy = 1'b0;
    logic [1:0]  hs_q       = 2'b00;
    logic [7:0]  held       = 8'h00;
    logic        mon_ok     = 1'b0;
    int          stable_err = 0;

    logic [7:0]  txlog [$];
    logic [8:0]  q0 [$];
    logic [8:0]  q1 [$];
    logic [1:0]  gtrace [$];
    logic [7:0]  exp3 [0:6];

    uart_tx_arbiter #(
        .NUM_REQ   (2),
        .MAX_BURST (4),
        .DATA_W    (8)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .grant     (grant),
        .arb_busy  (arb_busy)
    );

    always #10 sys_clk = ~sys_clk;

    assign tx_busy = force_busy || (busy_cnt != 0);

    // uart_tx model plus handshake, transmit log and tx_data stability monitor.
    always @(posedge sys_clk) begin
        if (tx_start) busy_cnt <= 20;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        if (tx_start) begin
            txlog.push_back(tx_data);
            held   <= tx_data;
            mon_ok <= 1'b1;
        end else if (sys_rst) begin
            mon_ok <= 1'b0;
        end else if (mon_ok && busy_cnt != 0 && tx_data != held) begin
            stable_err <= stable_err + 1;
        end
        hs_q <= req_valid & req_ready;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic present();
        req_valid[0] = (q0.size() != 0);
        req_valid[1] = (q1.size() != 0);
        if (q0.size() != 0) {req_last[0], req_data[7:0]} = q0[0];
        else {req_last[0], req_data[7:0]} = 9'h000;
        if (q1.size() != 0) {req_last[1], req_data[15:8]} = q1[0];
        else {req_last[1], req_data[15:8]} = 9'h000;
    endtask

    task automatic step();
        @(negedge sys_clk);
        if (hs_q[0] && q0.size() != 0) void'(q0.pop_front());
        if (hs_q[1] && q1.size() != 0) void'(q1.pop_front());
        present();
        if (gtrace.size() == 0 || gtrace[gtrace.size()-1] != grant) gtrace.push_back(grant);
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n = 0;
        step();
        while ((arb_busy || tx_busy || q0.size() != 0 || q1.size() != 0 || req_valid != 2'b00)
               && n < limit) begin
            step();
            n++;
        end
        chk(tag, 32'(n < limit), 32'd1);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        step();
        step();
        sys_rst = 1'b0;
        step();
    endtask

    initial begin
        int base;
        int viol;
        int n;

        // Reset state
        step();
        step();
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_arb_busy", 32'(arb_busy), 32'd0);
        sys_rst = 1'b0;
        step();

        // Single request with exact latency
        base = txlog.size();
        q0.push_back({1'b1, 8'h55});
        step();
        chk("t1_idle_grant", 32'(grant), 32'h0);
        step();
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_ready", 32'(req_ready), 32'h1);
        step();
        chk("t1_start", 32'(tx_start), 32'd1);
        chk("t1_data", 32'(tx_data), 32'h55);
        step();
        chk("t1_pulse", 32'(tx_start), 32'd0);
        chk("t1_grant_xfer", 32'(grant), 32'h1);
        wait_done("t1_done", 100);
        chk("t1_count", 32'(txlog.size() - base), 32'd1);
        chk("t1_grant_end", 32'(grant), 32'h0);
        chk("t1_ptr", 32'(dut.ptr_r), 32'd1);

        // Contention from reset, twice
        do_reset();
        for (int r = 0; r < 2; r++) begin
            base = txlog.size();
            q0.push_back({1'b1, 8'hA1});
            q1.push_back({1'b1, 8'hB2});
            wait_done($sformatf("t2_done%0d", r), 200);
            chk($sformatf("t2_count%0d", r), 32'(txlog.size() - base), 32'd2);
            chk($sformatf("t2_first%0d", r), 32'(txlog[base]), 32'hA1);
            chk($sformatf("t2_second%0d", r), 32'(txlog[base+1]), 32'hB2);
        end

        // Burst cap of 4 lets req1 in mid-stream
        base = txlog.size();
        for (int i = 0; i < 6; i++) q0.push_back({1'b0, 8'(8'h10 + i)});
        q1.push_back({1'b1, 8'h99});
        exp3[0] = 8'h10; exp3[1] = 8'h11; exp3[2] = 8'h12; exp3[3] = 8'h13;
        exp3[4] = 8'h99; exp3[5] = 8'h14; exp3[6] = 8'h15;
        wait_done("t3_done", 400);
        chk("t3_count", 32'(txlog.size() - base), 32'd7);
        for (int i = 0; i < 7; i++) chk($sformatf("t3_ord%0d", i), 32'(txlog[base+i]), 32'(exp3[i]));

        // req_last ends the burst early
        do_reset();
        gtrace.delete();
        base = txlog.size();
        q0.push_back({1'b0, 8'h20});
        q0.push_back({1'b1, 8'h21});
        q1.push_back({1'b1, 8'h30});
        wait_done("t4_done", 300);
        chk("t4_count", 32'(txlog.size() - base), 32'd3);
        chk("t4_b0", 32'(txlog[base]), 32'h20);
        chk("t4_b1", 32'(txlog[base+1]), 32'h21);
        chk("t4_b2", 32'(txlog[base+2]), 32'h30);
        chk("t4_gtrace_len", 32'(gtrace.size()), 32'd5);
        chk("t4_g1", 32'(gtrace[1]), 32'h1);
        chk("t4_g2", 32'(gtrace[2]), 32'h0);
        chk("t4_g3", 32'(gtrace[3]), 32'h2);

        // tx_busy held high while idle blocks the grant
        base = txlog.size();
        force_busy = 1'b1;
        q0.push_back({1'b1, 8'h77});
        viol = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (grant != 2'b00 || tx_start) viol++;
        end
        chk("t5_hold", 32'(viol), 32'd0);
        force_busy = 1'b0;
        step();
        chk("t5_grant", 32'(grant), 32'h1);
        chk("t5_nostart", 32'(tx_start), 32'd0);
        step();
        chk("t5_start", 32'(tx_start), 32'd1);
        chk("t5_data", 32'(tx_data), 32'h77);
        wait_done("t5_done", 100);

        // Reset during the second frame of a req1 burst
        base = txlog.size();
        q1.push_back({1'b0, 8'hC1});
        q1.push_back({1'b0, 8'hC2});
        q1.push_back({1'b1, 8'hC3});
        n = 0;
        while (txlog.size() < base + 2 && n < 200) begin
            step();
            n++;
        end
        chk("t6_two_frames", 32'(n < 200), 32'd1);
        step();
        step();
        step();
        sys_rst = 1'b1;
        #1;
        chk("t6_rst_start", 32'(tx_start), 32'd0);
        chk("t6_rst_data", 32'(tx_data), 32'h00);
        chk("t6_rst_grant", 32'(grant), 32'h0);
        chk("t6_rst_ready", 32'(req_ready), 32'h0);
        chk("t6_rst_busy", 32'(arb_busy), 32'd0);
        chk("t6_frame_running", 32'(tx_busy), 32'd1);
        q0.push_back({1'b1, 8'hD0});
        step();
        step();
        sys_rst = 1'b0;
        viol = 0;
        n = 0;
        while (tx_busy && n < 50) begin
            step();
            if (grant != 2'b00) viol++;
            n++;
        end
        chk("t6_frame_end", 32'(n < 50), 32'd1);
        chk("t6_no_grant_busy", 32'(viol), 32'd0);
        wait_done("t6_done", 200);
        chk("t6_count", 32'(txlog.size() - base), 32'd4);
        chk("t6_after0", 32'(txlog[base+2]), 32'hD0);
        chk("t6_after1", 32'(txlog[base+3]), 32'hC3);

        chk("tx_data_stable", 32'(stable_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (8N1, 9600 baud at 50 MHz `sys_clk`) between N byte-stream requesters, e.g. the loopback echo path and a status/message source.
- Arbitration is round-robin with burst locking: a granted requester keeps the transmitter until it marks its last byte, drops valid, or reaches MAX_BURST bytes.
- Sits between the requesters and `uart_tx`. It drives `tx_start`/`tx_data` and observes `tx_busy`.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- MAX_BURST, 4, maximum bytes sent per grant before re-arbitration (1..255).
- DATA_W, 8, byte width (fixed to 8 for UART).

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester byte available.
- req_data  input  NUM_REQ*DATA_W  flattened bytes; requester i occupies [i*8 +: 8].
- req_last  input  NUM_REQ  byte presented is the last of its packet.
- req_ready  output  NUM_REQ  byte accepted this cycle (valid & ready = handshake).
- tx_start  output  1  one-cycle pulse to uart_tx.
- tx_data  output  DATA_W  byte for uart_tx; stable from tx_start until tx_busy falls.
- tx_busy  input  1  uart_tx frame in progress; must rise the cycle after tx_start.
- grant  output  NUM_REQ  one-hot current owner; 0 when idle.
- arb_busy  output  1  state != IDLE.

Behaviour:
- Clocking and reset
  - Single clock; all flops use async active-high sys_rst.
  - Reset values: tx_start=0, tx_data=0, grant=0, req_ready=0, arb_busy=0, state=IDLE, rr pointer=0, burst count=0.
- States: IDLE, SEND, GUARD, WAIT.
- IDLE
  - If tx_busy=0 and any req_valid=1: pick the first valid index searching from the pointer upward with wrap.
  - Register grant one-hot and clear burst count; next state SEND.
  - If tx_busy=1: stay in IDLE and grant nothing.
- SEND
  - req_ready[g] = req_valid[g] (combinational, gated by state==SEND and grant[g]); all other ready bits are 0.
  - On handshake: register tx_data=req_data[g], tx_start=1 next cycle, latch req_last[g] into last_f, increment burst count; next state GUARD.
  - If req_valid[g]=0: next state IDLE, grant cleared, pointer=g+1 (wrap).
- GUARD
  - tx_start is high for exactly this one cycle; tx_busy is ignored; next state WAIT.
- WAIT
  - Hold until tx_busy=0.
  - Then, if last_f=0, burst count < MAX_BURST and req_valid[g]=1: go to SEND with the same grant.
  - Otherwise go to IDLE, clear grant, pointer=g+1 mod NUM_REQ.
- Latency
  - req_valid rises in IDLE at cycle 0: grant at cycle 1, ready/handshake at cycle 1, tx_start at cycle 2.
  - Minimum inter-byte gap within a burst: 1 cycle after tx_busy falls (SEND handshake), tx_start 1 cycle later.
- Arithmetic
  - Burst count is 8 bits and saturates at MAX_BURST.
  - Pointer is log2(NUM_REQ) bits and wraps modulo NUM_REQ, including non-power-of-two values.
- Boundary conditions
  - Simultaneous valid on all requesters: pointer order strictly rotates, so there is no starvation.
  - A requester asserting valid during another's burst waits at most MAX_BURST frames.
  - req_last together with burst count = MAX_BURST: single release, pointer advances once.
  - tx_data is never changed while tx_busy=1.
- Reset mid-operation
  - All outputs clear immediately.
  - A uart_tx frame already running completes on its own; IDLE waits for tx_busy=0 before the next grant.
  - The interrupted byte is not retransmitted.

Decomposition:
- Shared package uart_pkg:
  - state typedef/encoding (IDLE=0, SEND=1, GUARD=2, WAIT=3);
  - DATA_W=8;
  - BAUD_DIV=5208 (50 MHz / 9600), shared with uart_rx/uart_tx.
- One natural sub-module: rr_pick, a combinational round-robin selector.
  - Inputs: req vector, pointer.
  - Outputs: one-hot winner and its index, via a double-width masked priority encode.
- FSM, burst counter and data register stay in uart_tx_arbiter.

Test Plan:
- Bench uses a behavioural uart_tx model with tx_busy held for 20 cycles after tx_start; NUM_REQ=2, MAX_BURST=4 unless stated.
- Single request: req0 sends 0x55 with last=1 -> one tx_start, tx_data=0x55, grant=01 during the transfer, return to IDLE, pointer=1.
- Contention: from reset, req0=0xA1 and req1=0xB2, both last=1, both valid -> transmit order 0xA1, 0xB2. Repeat -> order 0xA1, 0xB2 again (pointer wrapped to 0).
- Burst cap: req0 streams 0x10..0x15 with last=0; req1 holds 0x99 valid -> order 0x10, 0x11, 0x12, 0x13, 0x99, 0x14, 0x15.
- Last terminates burst: req0 sends 0x20, then 0x21 with last=1; req1 holds 0x30 -> order 0x20, 0x21, 0x30; grant changes 01→00→10.
- Busy at idle: tx_busy forced high for 50 cycles with req0 valid -> no tx_start and grant=0 until tx_busy falls; tx_start exactly 2 cycles after it falls.
- Reset mid-burst: assert sys_rst during WAIT of the second byte of a req1 burst -> all outputs 0 immediately. After release with tx_busy still high, no grant until the frame ends. Next service starts at req0.
